move_sequencer: RTL
===================

Name: move_sequencer

Overview:
- Sits between the keypad decoder and the labyrinth text ROM / VGA pixel path.
- Queues direction keypresses and checks each candidate move against an external legality lookup.
- Commits position updates only at frame boundaries so the screen never tears mid-frame.
- Blanks the display for a programmable number of frames after each committed move (room transition).

Parameters:
- START_POS, 8'h00, player position loaded on reset, format {row[3:0], col[3:0]}.
- BLANK_FRAMES, 2, frames blank_o stays high after a committed move; 0 disables blanking.
- FIFO_DEPTH, 4, key queue depth; fixed power of two, fifo_level_o is log2(FIFO_DEPTH)+1 bits.
- VSYNC_ACTIVE_LOW, 1, sync polarity of vsync_i; 1 = pulse is low.
- KEY_UP / KEY_DOWN / KEY_LEFT / KEY_RIGHT, 4'h2 / 4'h8 / 4'h4 / 4'h6, keypad codes for the four directions.

Ports:
- clk_50MHz_i  in  1  system clock, 50 MHz.
- rst_sync_ha_i  in  1  reset, synchronous, active-high.
- key_i  in  4  decoded keypad code.
- key_valid_i  in  1  one-cycle strobe qualifying key_i (keypad one-shot).
- vsync_i  in  1  VGA vertical sync from the VGA timing block.
- cand_pos_o  out  8  candidate position presented to the legality lookup.
- legal_i  in  1  combinational legality of cand_pos_o; 1 = open cell.
- player_pos_o  out  8  committed player position, drives the ROM address.
- blank_o  out  1  1 = force VGA RGB to black.
- move_done_o  out  1  one-cycle pulse when a move commits.
- move_rej_o  out  1  one-cycle pulse when a move is rejected.
- busy_o  out  1  1 whenever state != IDLE.
- fifo_level_o  out  3  current queue occupancy, 0..4.
- drop_cnt_o  out  4  saturating count of keys dropped on a full queue.

Behaviour:
- Reset state:
  - player_pos_o = START_POS; cand_pos_o = START_POS.
  - blank_o, move_done_o, move_rej_o, busy_o = 0.
  - Queue empty; fifo_level_o = 0; drop_cnt_o = 0; state = IDLE.
- Reset priority: reset is synchronous and overrides everything, including mid-move and mid-blank. blank_o falls on the first clock edge with reset asserted.
- Frame boundary (frame_start):
  - Internal one-cycle pulse on the clock after vsync_i enters its active level (edge detect through one register).
  - The edge-detect register resets to the inactive level.
- Enqueue:
  - Condition: key_valid_i=1 and key_i matches one of the four direction codes.
  - Other codes are ignored: not queued, not counted.
  - If level == FIFO_DEPTH at the start of the cycle, the key is dropped and drop_cnt_o increments, saturating at 15. This holds even if a pop occurs in the same cycle.
  - Simultaneous push and pop on a non-full queue leaves the level unchanged.
- State machine:
  - IDLE: if level > 0, go to WAIT_FRAME.
  - WAIT_FRAME: on frame_start, pop the queue head into cur_dir and go to CHECK. Otherwise hold.
  - CHECK (exactly 1 cycle):
    - cand_pos_o = player_pos with row −1 / +1 or col −1 / +1 per cur_dir.
    - Off-grid moves are illegal regardless of legal_i: UP at row 0, DOWN at row 15, LEFT at col 0, RIGHT at col 15. No wrap-around; cand_pos_o holds player_pos in these cases.
    - legal_i is sampled at the end of this cycle.
    - If in-bounds and legal_i=1, go to COMMIT. Otherwise pulse move_rej_o the next cycle and go to IDLE.
  - COMMIT (1 cycle):
    - player_pos_o <= cand_pos_o; move_done_o pulses the same cycle.
    - If BLANK_FRAMES > 0: blank_o <= 1, frame counter loaded with BLANK_FRAMES, go to BLANK.
    - If BLANK_FRAMES = 0: go to IDLE.
  - BLANK: decrement the counter on each frame_start. The decrement that reaches 0 clears blank_o on the next edge and returns to IDLE.
- Outside CHECK, cand_pos_o holds its last value.
- Keys arriving in any state are still enqueued.
- Latency: key strobe to player_pos_o update = wait for the next frame_start + 2 cycles. With BLANK_FRAMES=N, the next queued move cannot commit until N frames later.
- Rule: at most one move commits per frame.

Test Plan:
- Reset with START_POS=8'h55, then key_valid_i with KEY_RIGHT and legal_i=1. Assert vsync low → frame_start. Required: move_done_o pulse, player_pos_o=8'h56, blank_o high for exactly 2 frame_start pulses, then busy_o=0.
- At pos 8'h50, issue KEY_LEFT. Required: move_rej_o pulse, player_pos_o stays 8'h50, blank_o stays 0.
- At pos 8'h55 with legal_i=0, issue KEY_UP. Required: cand_pos_o=8'h45 during CHECK, move_rej_o pulse, position unchanged.
- Issue 6 direction keys back-to-back with no vsync. Required: fifo_level_o=4, drop_cnt_o=2. Then 4 moves commit across frames in FIFO order, at most one per frame.
- Issue key 4'hA, then key 4'h0. Required: fifo_level_o stays 0, drop_cnt_o stays 0.
- During BLANK, assert rst_sync_ha_i for 1 cycle. Required: the next cycle shows blank_o=0, player_pos_o=START_POS, fifo_level_o=0, state IDLE.

Source files
------------

// File: rtl/move_sequencer_if.sv
// move_sequencer_if: bundles the keypad, VGA sync, legality lookup and status
// signals exchanged between the move sequencer and its surroundings.
interface move_sequencer_if;
  logic [3:0] key_i;
  logic       key_valid_i;
  logic       vsync_i;
  logic       legal_i;
  logic [7:0] cand_pos_o;
  logic [7:0] player_pos_o;
  logic       blank_o;
  logic       move_done_o;
  logic       move_rej_o;
  logic       busy_o;
  logic [2:0] fifo_level_o;
  logic [3:0] drop_cnt_o;

  // Environment side: keypad decoder, VGA timing and legality lookup
  modport master (
    output key_i, key_valid_i, vsync_i, legal_i,
    input  cand_pos_o, player_pos_o, blank_o, move_done_o, move_rej_o,
           busy_o, fifo_level_o, drop_cnt_o
  );

  // Sequencer side
  modport slave (
    input  key_i, key_valid_i, vsync_i, legal_i,
    output cand_pos_o, player_pos_o, blank_o, move_done_o, move_rej_o,
           busy_o, fifo_level_o, drop_cnt_o
  );
endinterface

// File: rtl/move_sequencer.sv
// move_sequencer: queues direction keys, checks each candidate move against
// the legality lookup, commits at most one move per frame and blanks the
// display for a number of frames after every committed move.
module move_sequencer #(
  parameter logic [7:0] START_POS        = 8'h00,
  parameter int         BLANK_FRAMES     = 2,
  parameter int         FIFO_DEPTH       = 4,
  parameter bit         VSYNC_ACTIVE_LOW = 1'b1,
  parameter logic [3:0] KEY_UP           = 4'h2,
  parameter logic [3:0] KEY_DOWN         = 4'h8,
  parameter logic [3:0] KEY_LEFT         = 4'h4,
  parameter logic [3:0] KEY_RIGHT        = 4'h6
) (
  input  logic            clk_50MHz_i,
  input  logic            rst_sync_ha_i,
  move_sequencer_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL   = LVL_W'(FIFO_DEPTH);
  localparam logic [7:0]       BLANK_LOAD = 8'(BLANK_FRAMES);

  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
  typedef enum logic [2:0] {IDLE, WAIT_FRAME, CHECK, COMMIT, BLANK} state_t;

  state_t state_q, state_d;

  logic             vsync_active, vsync_prev_q, frame_start;
  logic             key_is_dir, push, pop, drop, full;
  dir_t             key_dir;
  dir_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic [3:0]       drop_cnt_q;
  logic [7:0]       player_pos_q, cand_pos_q, blank_cnt_q;
  logic             cand_ok_q, blank_q, move_rej_q;
  logic             busy, move_done;

  // Candidate position for one step; MSB flags an in-grid move, and an
  // off-grid step returns the unchanged position (no wrap-around).
  function automatic logic [8:0] step_pos(input logic [7:0] pos, input dir_t dir);
    logic [3:0] row;
    logic [3:0] col;
    logic [8:0] res;
    row = pos[7:4];
    col = pos[3:0];
    res = {1'b0, pos};
    case (dir)
      DIR_UP:    if (row != 4'h0) res = {1'b1, row - 4'd1, col};
      DIR_DOWN:  if (row != 4'hF) res = {1'b1, row + 4'd1, col};
      DIR_LEFT:  if (col != 4'h0) res = {1'b1, row, col - 4'd1};
      default:   if (col != 4'hF) res = {1'b1, row, col + 4'd1};
    endcase
    return res;
  endfunction

  assign vsync_active = VSYNC_ACTIVE_LOW ? ~bus.vsync_i : bus.vsync_i;
  assign frame_start  = vsync_active & ~vsync_prev_q;

  // Remember last vsync level so frame_start fires once per frame
  always_ff @(posedge clk_50MHz_i) begin
    if (rst_sync_ha_i) vsync_prev_q <= 1'b0;
    else               vsync_prev_q <= vsync_active;
  end

  // Map keypad codes to directions; anything else is not a move key
  always_comb begin
    key_is_dir = 1'b1;
    key_dir    = DIR_UP;
    case (bus.key_i)
      KEY_UP:    key_dir = DIR_UP;
      KEY_DOWN:  key_dir = DIR_DOWN;
      KEY_LEFT:  key_dir = DIR_LEFT;
      KEY_RIGHT: key_dir = DIR_RIGHT;
      default:   key_is_dir = 1'b0;
    endcase
  end

  assign full = (level_q == FULL_LVL);
  assign push = bus.key_valid_i & key_is_dir & ~full;
  assign drop = bus.key_valid_i & key_is_dir & full;
  assign pop  = (state_q == WAIT_FRAME) & frame_start;

  // Key queue storage; contents are don't-care until written
  always_ff @(posedge clk_50MHz_i) begin
    if (push) fifo_mem[wr_ptr_q] <= key_dir;
  end

  // Queue pointers, occupancy and saturating drop counter
  always_ff @(posedge clk_50MHz_i) begin
    if (rst_sync_ha_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (drop && drop_cnt_q != 4'hF) drop_cnt_q <= drop_cnt_q + 4'd1;
    end
  end

  // FSM state register
  always_ff @(posedge clk_50MHz_i) begin
    if (rst_sync_ha_i) state_q <= IDLE;
    else               state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (level_q != '0) state_d = WAIT_FRAME;
      WAIT_FRAME: if (frame_start) state_d = CHECK;
      CHECK:      state_d = (cand_ok_q && bus.legal_i) ? COMMIT : IDLE;
      COMMIT:     state_d = (BLANK_FRAMES > 0) ? BLANK : IDLE;
      BLANK:      if (frame_start && blank_cnt_q == 8'd1) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    busy      = (state_q != IDLE);
    move_done = (state_q == COMMIT);
  end

  // Move datapath: candidate on pop, commit, blanking frames, reject pulse
  always_ff @(posedge clk_50MHz_i) begin
    if (rst_sync_ha_i) begin
      player_pos_q <= START_POS;
      cand_pos_q   <= START_POS;
      cand_ok_q    <= 1'b0;
      blank_q      <= 1'b0;
      blank_cnt_q  <= 8'd0;
      move_rej_q   <= 1'b0;
    end else begin
      move_rej_q <= (state_q == CHECK) && !(cand_ok_q && bus.legal_i);
      if (pop) {cand_ok_q, cand_pos_q} <= step_pos(player_pos_q, fifo_mem[rd_ptr_q]);
      if (state_q == COMMIT) begin
        player_pos_q <= cand_pos_q;
        if (BLANK_FRAMES > 0) begin
          blank_q     <= 1'b1;
          blank_cnt_q <= BLANK_LOAD;
        end
      end
      if (state_q == BLANK && frame_start) begin
        blank_cnt_q <= blank_cnt_q - 8'd1;
        if (blank_cnt_q == 8'd1) blank_q <= 1'b0;
      end
    end
  end

  assign bus.cand_pos_o   = cand_pos_q;
  assign bus.player_pos_o = player_pos_q;
  assign bus.blank_o      = blank_q;
  assign bus.move_done_o  = move_done;
  assign bus.move_rej_o   = move_rej_q;
  assign bus.busy_o       = busy;
  assign bus.fifo_level_o = level_q;
  assign bus.drop_cnt_o   = drop_cnt_q;
endmodule
